// File: rtl/cnn_result_reader.sv
// cnn_result_reader: fetches bus beats from the result RAM read port one at a
// time and unpacks each beat into DATA_WIDTH words on a valid/ready stream,
// lane 0 first, with lastOut on the final word of the transfer.
module cnn_result_reader #(
    parameter int BUS_ADDR_WIDTH = 32,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_SIZE       = 4096,
    parameter int RD_LATENCY     = 1,
    localparam int CNT_WIDTH     = $clog2(MAX_SIZE) + 1
) (
    input  logic                      clkIn,
    input  logic                      rstIn,
    input  logic                      startIn,
    input  logic [BUS_ADDR_WIDTH-1:0] baseAddrIn,
    input  logic [CNT_WIDTH-1:0]      numWordsIn,
    output logic                      rdEnOut,
    output logic [BUS_ADDR_WIDTH-1:0] rdAddrOut,
    input  logic [BUS_DATA_WIDTH-1:0] rdDataIn,
    input  logic                      readyIn,
    output logic                      validOut,
    output logic [DATA_WIDTH-1:0]     dataOut,
    output logic                      lastOut,
    output logic                      busyOut,
    output logic                      doneOut
);

    localparam int NUM_WORDS  = BUS_DATA_WIDTH / DATA_WIDTH;
    localparam int BEAT_BYTES = BUS_DATA_WIDTH / 8;
    localparam int LANE_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int LAT_W      = $clog2(RD_LATENCY + 1);

    localparam logic [BUS_ADDR_WIDTH-1:0] ADDR_STEP  = BUS_ADDR_WIDTH'(BEAT_BYTES);
    localparam logic [BUS_ADDR_WIDTH-1:0] ALIGN_MASK = ~BUS_ADDR_WIDTH'(BEAT_BYTES - 1);
    localparam logic [LANE_W-1:0]         LAST_LANE  = LANE_W'(NUM_WORDS - 1);
    localparam logic [LAT_W-1:0]          LAT_DONE   = LAT_W'(RD_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_EMIT,
        S_FIN
    } state_t;

    state_t                              state;
    logic [BUS_ADDR_WIDTH-1:0]           next_addr;
    logic [CNT_WIDTH-1:0]                remaining;
    logic [LANE_W-1:0]                   lane;
    logic [LANE_W-1:0]                   next_lane;
    logic [LAT_W-1:0]                    lat_cnt;
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] beat;
    logic                                capture;
    logic                                beat_end;

    // Base addresses are forced onto a beat boundary.
    function automatic logic [BUS_ADDR_WIDTH-1:0] align_addr(input logic [BUS_ADDR_WIDTH-1:0] a);
        return a & ALIGN_MASK;
    endfunction

    assign next_lane = lane + LANE_W'(1);
    assign capture   = (state == S_WAIT) && (lat_cnt == LAT_DONE);
    // A beat ends on its top lane, or early when the transfer runs out of words.
    assign beat_end  = (lane == LAST_LANE) || (remaining == CNT_WIDTH'(1));

    // Beat holding register: loaded on the cycle the read data is valid.
    always_ff @(posedge clkIn) begin
        if (capture) begin
            beat <= rdDataIn;
        end
    end

    // Transfer sequencer with registered strobe, stream and status outputs.
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            state     <= S_IDLE;
            next_addr <= '0;
            remaining <= '0;
            lane      <= '0;
            lat_cnt   <= '0;
            rdEnOut   <= 1'b0;
            rdAddrOut <= '0;
            validOut  <= 1'b0;
            dataOut   <= '0;
            lastOut   <= 1'b0;
            busyOut   <= 1'b0;
            doneOut   <= 1'b0;
        end else begin
            rdEnOut <= 1'b0;
            doneOut <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (startIn) begin
                        busyOut   <= 1'b1;
                        remaining <= numWordsIn;
                        if (numWordsIn == '0) begin
                            doneOut <= 1'b1;
                            state   <= S_FIN;
                        end else begin
                            // Strobe goes out while the FSM sits in READ.
                            rdEnOut   <= 1'b1;
                            rdAddrOut <= align_addr(baseAddrIn);
                            next_addr <= align_addr(baseAddrIn) + ADDR_STEP;
                            state     <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    lat_cnt <= LAT_W'(1);
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (capture) begin
                        lane     <= '0;
                        validOut <= 1'b1;
                        dataOut  <= rdDataIn[DATA_WIDTH-1:0];
                        lastOut  <= (remaining == CNT_WIDTH'(1));
                        state    <= S_EMIT;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                S_EMIT: begin
                    if (validOut && readyIn) begin
                        remaining <= remaining - CNT_WIDTH'(1);
                        if (beat_end) begin
                            validOut <= 1'b0;
                            lastOut  <= 1'b0;
                            if (remaining == CNT_WIDTH'(1)) begin
                                doneOut <= 1'b1;
                                state   <= S_FIN;
                            end else begin
                                rdEnOut   <= 1'b1;
                                rdAddrOut <= next_addr;
                                next_addr <= next_addr + ADDR_STEP;
                                state     <= S_READ;
                            end
                        end else begin
                            lane    <= next_lane;
                            dataOut <= beat[next_lane];
                            lastOut <= (remaining == CNT_WIDTH'(2));
                        end
                    end
                end
                S_FIN: begin
                    busyOut <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_result_reader.sv
// Bench for cnn_result_reader: a latency-1 instance checked through address
// and word scoreboards, plus a latency-3 instance for the alignment/timing case.
module tb_cnn_result_reader;

    logic        clk;
    logic        rstIn;
    logic        startIn;
    logic [31:0] baseAddrIn;
    logic [12:0] numWordsIn;
    logic        rdEnOut;
    logic [31:0] rdAddrOut;
    logic [63:0] rdDataIn;
    logic        readyIn;
    logic        validOut;
    logic [31:0] dataOut;
    logic        lastOut;
    logic        busyOut;
    logic        doneOut;

    logic        start3;
    logic [31:0] base3;
    logic [12:0] num3;
    logic        rdEn3;
    logic [31:0] rdAddr3;
    logic [63:0] rdData3;
    logic        ready3;
    logic        valid3;
    logic [31:0] data3;
    logic        last3;
    logic        busy3;
    logic        done3;

    localparam logic [63:0] GARBAGE = 64'hDEAD_BEEF_DEAD_BEEF;

    int vectors = 0;
    int errors  = 0;
    int done_cnt = 0;
    int acc_cnt  = 0;
    int acc_base = 0;
    int mode     = 0;

    logic [31:0] exp_a[$];
    logic [32:0] exp_w[$];

    logic [63:0] pipe1;
    logic [63:0] pipe3_0, pipe3_1, pipe3_2;

    cnn_result_reader dut (
        .clkIn(clk), .rstIn(rstIn), .startIn(startIn), .baseAddrIn(baseAddrIn),
        .numWordsIn(numWordsIn), .rdEnOut(rdEnOut), .rdAddrOut(rdAddrOut),
        .rdDataIn(rdDataIn), .readyIn(readyIn), .validOut(validOut),
        .dataOut(dataOut), .lastOut(lastOut), .busyOut(busyOut), .doneOut(doneOut)
    );

    cnn_result_reader #(.RD_LATENCY(3)) dut3 (
        .clkIn(clk), .rstIn(rstIn), .startIn(start3), .baseAddrIn(base3),
        .numWordsIn(num3), .rdEnOut(rdEn3), .rdAddrOut(rdAddr3),
        .rdDataIn(rdData3), .readyIn(ready3), .validOut(valid3),
        .dataOut(data3), .lastOut(last3), .busyOut(busy3), .doneOut(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: beat at byte address a holds {a/4+2, a/4+1}.
    function automatic logic [63:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a >> 2;
        return {w + 32'd2, w + 32'd1};
    endfunction

    // Read ports: garbage whenever the data is not the delayed response.
    always @(posedge clk) begin
        pipe1   <= rdEnOut ? mem_word(rdAddrOut) : GARBAGE;
        pipe3_0 <= rdEn3 ? mem_word(rdAddr3) : GARBAGE;
        pipe3_1 <= pipe3_0;
        pipe3_2 <= pipe3_1;
    end
    assign rdDataIn = pipe1;
    assign rdData3  = pipe3_2;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Ready driver: always high, or toggling with a 5-cycle hold on word 2.
    initial begin
        int stall_cnt;
        stall_cnt = 0;
        readyIn = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (mode == 0) begin
                readyIn   = 1'b1;
                stall_cnt = 0;
            end else if ((acc_cnt - acc_base) == 1 && stall_cnt < 5) begin
                readyIn = 1'b0;
                stall_cnt++;
            end else begin
                readyIn = ~readyIn;
            end
        end
    end

    // Monitor: pops and compares on read strobes and stream handshakes.
    initial begin
        logic        held_vld;
        logic [32:0] held;
        logic [32:0] e;
        held_vld = 1'b0;
        held     = '0;
        forever begin
            @(negedge clk);
            if (rstIn) begin
                held_vld = 1'b0;
            end else begin
                if (rdEnOut) begin
                    if (exp_a.size() == 0) check("rd_unexpected", {32'd0, rdAddrOut}, 64'hFFFF_FFFF_FFFF_FFFF);
                    else check("rd_addr", {32'd0, rdAddrOut}, {32'd0, exp_a.pop_front()});
                end
                if (held_vld && !validOut) check("valid_dropped", 0, 1);
                if (validOut) begin
                    if (held_vld) check("stall_stable", {31'd0, lastOut, dataOut}, {31'd0, held});
                    if (readyIn) begin
                        if (exp_w.size() == 0) begin
                            check("word_unexpected", {31'd0, lastOut, dataOut}, 64'hFFFF_FFFF_FFFF_FFFF);
                        end else begin
                            e = exp_w.pop_front();
                            check("word", {31'd0, lastOut, dataOut}, {31'd0, e});
                        end
                        acc_cnt++;
                        held_vld = 1'b0;
                    end else begin
                        held_vld = 1'b1;
                        held     = {lastOut, dataOut};
                    end
                end else begin
                    held_vld = 1'b0;
                end
                if (doneOut) done_cnt++;
            end
        end
    end

    task automatic run(input logic [31:0] base, input int n, input int budget, output int cycles);
        logic [31:0] al;
        int d0;
        al = base & 32'hFFFF_FFF8;
        for (int b = 0; b < (n + 1) / 2; b++) exp_a.push_back(al + 32'(b * 8));
        for (int w = 0; w < n; w++) exp_w.push_back({(w == n - 1), (al >> 2) + 32'(w + 1)});
        d0 = done_cnt;
        @(posedge clk); #1;
        startIn = 1'b1; baseAddrIn = base; numWordsIn = 13'(n);
        @(posedge clk); #1;
        startIn = 1'b0;
        check("busy_after_start", {63'd0, busyOut}, 1);
        cycles = 0;
        while (done_cnt == d0 && cycles < budget) begin
            @(posedge clk);
            cycles++;
        end
        check("done_timeout", {63'd0, (done_cnt == d0)}, 0);
        repeat (3) @(posedge clk);
        #1;
        check("done_once", 64'(done_cnt - d0), 1);
        check("words_left", 64'(exp_w.size()), 0);
        check("reads_left", 64'(exp_a.size()), 0);
        check("busy_idle", {63'd0, busyOut}, 0);
    endtask

    initial begin
        int cyc;
        int d0;
        logic found;
        rstIn = 1'b1; startIn = 1'b0; baseAddrIn = '0; numWordsIn = '0;
        start3 = 1'b0; base3 = '0; num3 = '0; ready3 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {25'd0, rdEnOut, rdAddrOut, validOut, lastOut, busyOut, doneOut, 2'd0},
              64'd0);
        check("reset_data", {32'd0, dataOut}, 0);
        rstIn = 1'b0;

        // T1: four words over two full beats.
        run(32'h0, 4, 100, cyc);
        // T2: partial last beat, upper lane never emitted.
        run(32'h0, 3, 100, cyc);
        // T3: toggling ready with a stall on word 2.
        acc_base = acc_cnt;
        mode = 1;
        run(32'h0, 4, 200, cyc);
        mode = 0;
        // T4: empty transfer.
        run(32'h0, 0, 10, cyc);
        check("zero_done_latency", {63'd0, (cyc <= 2)}, 1);

        // T5: latency-3 instance, unaligned base.
        begin
            int rd_cyc, rd_seen, k, dn;
            rd_cyc = -100; rd_seen = 0; k = 0; dn = 0;
            @(posedge clk); #1;
            start3 = 1'b1; base3 = 32'h1004; num3 = 13'd2;
            @(posedge clk); #1;
            start3 = 1'b0;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                if (rdEn3) begin
                    rd_seen++;
                    rd_cyc = c;
                    check("lat3_rd_addr", {32'd0, rdAddr3}, 64'h1000);
                end
                if (valid3) begin
                    if (k == 0) check("lat3_capture_delay", 64'(c - rd_cyc), 4);
                    check("lat3_word", {31'd0, last3, data3}, {31'd0, (k == 1), 32'h401 + 32'(k)});
                    k++;
                end
                if (done3) dn++;
            end
            check("lat3_reads", 64'(rd_seen), 1);
            check("lat3_words", 64'(k), 2);
            check("lat3_done", 64'(dn), 1);
        end

        // T6: reset during word 2 of an 8-word transfer, then a clean rerun.
        for (int b = 0; b < 4; b++) exp_a.push_back(32'(b * 8));
        for (int w = 0; w < 8; w++) exp_w.push_back({(w == 7), 32'(w + 1)});
        d0 = done_cnt;
        @(posedge clk); #1;
        startIn = 1'b1; baseAddrIn = 32'h0; numWordsIn = 13'd8;
        @(posedge clk); #1;
        startIn = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (validOut && dataOut == 32'd2) found = 1'b1;
        end
        check("abort_word2_seen", {63'd0, found}, 1);
        #2;
        rstIn = 1'b1;
        #1;
        check("abort_outputs", {25'd0, rdEnOut, rdAddrOut, validOut, lastOut, busyOut, doneOut, 2'd0},
              64'd0);
        check("abort_data", {32'd0, dataOut}, 0);
        exp_a.delete();
        exp_w.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rstIn = 1'b0;
        check("abort_no_done", 64'(done_cnt - d0), 0);
        run(32'h0, 2, 100, cyc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Watchdog against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
